// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared types and constants for the serial-to-parallel converter.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Word width used when the instantiating design does not override it.
    localparam int c_DEFAULT_WIDTH = 4;

    // Output holding register state: EMPTY has no word, FULL holds one.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Bits needed to count 0 .. w-1 (never less than one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/sipo_shift.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift
// Brief    : LSB-first serial shift register with a wrapping bit counter.
//            Raises word_done combinationally in the cycle whose edge samples
//            the final bit, with the completed word presented on 'word'.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift
    import shift_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clr,
    input  logic             sin_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic             busy
);

    localparam int                c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

    logic [WIDTH-1:0] r_sr;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_last;

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign w_sr_next = {sin, r_sr[WIDTH-1:1]};
    assign w_last    = (r_cnt == c_LAST);

    // Shift and count sampled bits; the counter wraps on the final bit.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (sin_valid) begin
            r_sr  <= w_sr_next;
            r_cnt <= w_last ? '0 : (r_cnt + c_ONE);
        end
    end

    // The completed word is the shift value about to be captured.
    assign word      = w_sr_next;
    assign word_done = sin_valid & w_last & ~clr;
    assign busy      = (r_cnt != '0);

endmodule : sipo_shift
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel
// Brief    : Collects LSB-first serial bits into WIDTH-bit words and offers
//            them on a valid/ready output with a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel
    import shift_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clr,
    input  logic             sin_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
);

    logic [WIDTH-1:0] w_word;
    logic             w_word_done;

    out_state_t       r_state;
    out_state_t       w_state_next;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_next;
    logic             r_overrun;
    logic             w_overrun_next;

    sipo_shift #(
        .WIDTH     (WIDTH)
    ) u_shift (
        .clk       (clk),
        .areset_n  (areset_n),
        .clr       (clr),
        .sin_valid (sin_valid),
        .sin       (sin),
        .word      (w_word),
        .word_done (w_word_done),
        .busy      (busy)
    );

    // Output state, held word and sticky overrun flag.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= EMPTY;
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dout    <= w_dout_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Next-state logic: load on completion, release on handshake, and drop
    // a completed word (flagging overrun) when the held word is not taken.
    always_comb begin
        w_state_next   = r_state;
        w_dout_next    = r_dout;
        w_overrun_next = r_overrun;

        if (clr) begin
            w_state_next   = EMPTY;
            w_dout_next    = '0;
            w_overrun_next = 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_word_done) begin
                        w_state_next = FULL;
                        w_dout_next  = w_word;
                    end
                end
                FULL: begin
                    if (w_word_done) begin
                        if (dout_ready) begin
                            w_dout_next = w_word;
                        end else begin
                            w_overrun_next = 1'b1;
                        end
                    end else if (dout_ready) begin
                        w_state_next = EMPTY;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = (r_state == FULL);
    assign overrun    = r_overrun;

endmodule : serial_to_parallel
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel
// Brief    : Self-checking bench for serial_to_parallel (WIDTH=4): directed
//            vector table, async-reset sequence and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

    localparam int c_W = 4;

    logic           clk;
    logic           areset_n;
    logic           clr;
    logic           sin_valid;
    logic           sin;
    logic [c_W-1:0] dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           overrun;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    serial_to_parallel #(
        .WIDTH      (c_W)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .clr        (clr),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit             c;
        bit             v;
        bit             s;
        bit             r;
        logic [c_W-1:0] e_dout;
        bit             e_valid;
        bit             e_ovr;
        bit             e_busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a queue of received bits and a one-word output slot.
    bit             m_bits[$];
    logic [c_W-1:0] m_dout;
    bit             m_valid;
    bit             m_ovr;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [c_W-1:0] e_dout,
                           input bit e_valid, input bit e_ovr, input bit e_busy);
        chk({tag, " dout"},       int'(dout),       int'(e_dout));
        chk({tag, " dout_valid"}, int'(dout_valid), int'(e_valid));
        chk({tag, " overrun"},    int'(overrun),    int'(e_ovr));
        chk({tag, " busy"},       int'(busy),       int'(e_busy));
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input bit c, input bit v, input bit s, input bit r);
        clr        = c;
        sin_valid  = v;
        sin        = s;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit c, input bit v, input bit s, input bit r);
        bit             done;
        bit             taken;
        logic [c_W-1:0] word;
        done = 1'b0;
        word = '0;
        if (c) begin
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (v) begin
                m_bits.push_back(s);
                if (m_bits.size() == c_W) begin
                    for (int i = 0; i < c_W; i++) word[i] = m_bits[i];
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            taken = m_valid && r;
            if (done) begin
                if (!m_valid || taken) begin
                    m_dout  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (taken) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic add(input bit c, input bit v, input bit s, input bit r,
                       input logic [c_W-1:0] d, input bit ev, input bit eo, input bit eb);
        vec_t t;
        t.c = c; t.v = v; t.s = s; t.r = r;
        t.e_dout = d; t.e_valid = ev; t.e_ovr = eo; t.e_busy = eb;
        vecs.push_back(t);
    endtask

    initial begin
        // Word 1101 then 0110 with a ready consumer.
        add(0,1,1,1, 4'h0,0,0,1); add(0,1,0,1, 4'h0,0,0,1);
        add(0,1,1,1, 4'h0,0,0,1); add(0,1,1,1, 4'hD,1,0,0);
        add(0,1,0,1, 4'hD,0,0,1); add(0,1,1,1, 4'hD,0,0,1);
        add(0,1,1,1, 4'hD,0,0,1); add(0,1,0,1, 4'h6,1,0,0);
        add(0,0,1,1, 4'h6,0,0,0); add(1,0,0,0, 4'h0,0,0,0);
        // Same bits with a stalled consumer: overrun, held word.
        add(0,1,1,0, 4'h0,0,0,1); add(0,1,0,0, 4'h0,0,0,1);
        add(0,1,1,0, 4'h0,0,0,1); add(0,1,1,0, 4'hD,1,0,0);
        add(0,1,0,0, 4'hD,1,0,1); add(0,1,1,0, 4'hD,1,0,1);
        add(0,1,1,0, 4'hD,1,0,1); add(0,1,0,0, 4'hD,1,1,0);
        add(0,0,0,0, 4'hD,1,1,0); add(0,0,0,1, 4'hD,0,1,0);
        add(0,0,0,0, 4'hD,0,1,0); add(1,1,1,1, 4'h0,0,0,0);
        // Ready arrives exactly on the second completion: no bubble.
        add(0,1,1,0, 4'h0,0,0,1); add(0,1,0,0, 4'h0,0,0,1);
        add(0,1,1,0, 4'h0,0,0,1); add(0,1,1,0, 4'hD,1,0,0);
        add(0,1,0,0, 4'hD,1,0,1); add(0,1,1,0, 4'hD,1,0,1);
        add(0,1,1,0, 4'hD,1,0,1); add(0,1,0,1, 4'h6,1,0,0);
        add(0,0,0,1, 4'h6,0,0,0);
        // Clear mid-word, then a clean word 0,0,1,0.
        add(0,1,1,0, 4'h6,0,0,1); add(0,1,1,0, 4'h6,0,0,1);
        add(1,1,1,0, 4'h0,0,0,0); add(0,1,0,0, 4'h0,0,0,1);
        add(0,1,0,0, 4'h0,0,0,1); add(0,1,1,0, 4'h0,0,0,1);
        add(0,1,0,0, 4'h4,1,0,0); add(0,0,0,1, 4'h4,0,0,0);

        areset_n   = 1'b0;
        clr        = 1'b0;
        sin_valid  = 1'b0;
        sin        = 1'b0;
        dout_ready = 1'b0;
        #12;
        chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        areset_n = 1'b1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].v, vecs[i].s, vecs[i].r);
            chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_valid,
                    vecs[i].e_ovr, vecs[i].e_busy);
        end

        // Randomized traffic against the model, starting from a clear.
        step(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            bit c, v, s, r;
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom);
            r = ($urandom_range(0, 2) != 0);
            step(c, v, s, r);
            model_step(c, v, s, r);
            chk_all($sformatf("rnd%0d", n), m_dout, m_valid, m_ovr, (m_bits.size() != 0));
        end

        // Async reset between edges while FULL, overrun set and mid-word.
        step(1, 0, 0, 0);
        step(0,1,1,0); step(0,1,0,0); step(0,1,1,0); step(0,1,1,0);
        step(0,1,0,0); step(0,1,1,0); step(0,1,1,0); step(0,1,0,0);
        step(0,1,1,0); step(0,1,1,0);
        chk_all("pre_areset", 4'hD, 1'b1, 1'b1, 1'b1);
        #2;
        areset_n = 1'b0;
        #1;
        chk_all("areset_async", 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        areset_n = 1'b1;
        // First bit after reset starts a fresh word.
        step(0,1,0,0);
        chk_all("post_areset_b0", 4'h0, 1'b0, 1'b0, 1'b1);
        step(0,1,0,0); step(0,1,1,0); step(0,1,0,0);
        chk_all("post_areset_word", 4'h4, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_to_parallel
`default_nettype wire

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter: WIDTH, default 4, word width in bits; legal range 2 to 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 areset_n  input  1  asynchronous, active-low reset; zeroes all state.
REQ-004 clr  input  1  synchronous clear of collection and output state.
REQ-005 sin_valid  input  1  serial bit strobe; sin is sampled on a clk edge where this is high.
REQ-006 sin  input  1  serial data bit, LSB of each word first.
REQ-007 dout  output  WIDTH  assembled parallel word.
REQ-008 dout_valid  output  1  dout holds an untransferred word.
REQ-009 dout_ready  input  1  consumer accepts dout on an edge where dout_valid is high.
REQ-010 overrun  output  1  sticky flag; a completed word was dropped.
REQ-011 busy  output  1  partial word is being collected (bit count not zero).

Function
REQ-012 On each edge with sin_valid=1, the shift register SHALL update to {sin, sr[WIDTH-1:1]} and bit count SHALL increment; with sin_valid=0, sin is ignored and nothing changes.
REQ-013 The WIDTH-th sampled bit SHALL complete a word equal to {sin, sr[WIDTH-1:1]}, first-received bit in dout[0], and bit count SHALL wrap to 0 on that edge.
REQ-014 Output FSM states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-015 EMPTY->FULL on word completion; dout loaded with the word on the same edge, so dout_valid rises the cycle after the WIDTH-th bit is sampled.
REQ-016 FULL->EMPTY on dout_valid and dout_ready with no completion on the same edge.
REQ-017 FULL with dout_ready=1 and completion on the same edge SHALL stay FULL with the new word loaded (back-to-back, no bubble).
REQ-018 FULL with dout_ready=0 and completion SHALL keep dout unchanged, drop the new word and set overrun.
REQ-019 dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-020 overrun SHALL remain set until clr or reset.
REQ-021 clr=1 SHALL zero sr, bit count, dout, dout_valid and overrun on the next edge, taking priority over sin_valid and dout_ready.
REQ-022 busy SHALL equal (bit count != 0), registered state only.
REQ-023 Collection SHALL continue while FULL; dout_ready SHALL NOT stall sin.

Reset
REQ-024 areset_n low SHALL immediately zero sr, bit count, dout, dout_valid, overrun and busy, and select EMPTY, independent of clk.
REQ-025 After areset_n deasserts, the first sampled bit SHALL be treated as bit 0 of a new word.

Structure
REQ-026 Package shift_pkg SHALL hold the FSM state enum typedef (EMPTY, FULL) and the default WIDTH constant.
REQ-027 Sub-module sipo_shift SHALL hold the shift register and wrapping bit counter and emit a one-cycle word_done pulse with the word; serial_to_parallel holds the FSM and output register.

Verification (WIDTH=4)
REQ-028 Reset, then bits 1,0,1,1 with dout_ready=1 -> dout=4'b1101 and dout_valid=1 in the cycle after the 4th bit, followed by one-cycle valid and EMPTY.
REQ-029 Eight consecutive bits 1,0,1,1,0,1,1,0 with dout_ready=1 -> dout=4'hD, then 4'h6 four cycles later, no overrun.
REQ-030 dout_ready=0, same eight bits -> dout holds 4'hD, overrun=1 after the 8th bit, busy=0.
REQ-031 Hold FULL and assert dout_ready exactly on the edge of the second completion -> dout_valid stays 1 and dout changes 4'hD to 4'h6 with no gap.
REQ-032 clr after 2 bits -> busy=0 next cycle; next bits 0,0,1,0 give dout=4'h4 with no stale bits.
REQ-033 areset_n pulse low between clk edges mid-word while FULL -> all outputs 0 immediately, before the next edge.
